// File: rtl/dsp_pkg.sv
// Shared definitions for the sail-core DSP datapath blocks.
//   OP_ADD / OP_SUB : encoding of the add/subtract select input
//   MAC16_HALF_W    : width of one iCE40 MAC16 adder half, the default slice width
package dsp_pkg;

  localparam logic OP_ADD       = 1'b0;
  localparam logic OP_SUB       = 1'b1;
  localparam int   MAC16_HALF_W = 16;

endpackage

// File: rtl/dsp_addsub_slice.sv
// Combinational W-bit adder slice; the piece that maps onto one MAC16 adder half.
// Ports:
//   a, b  : slice operands (b already inverted by the caller for subtract)
//   cin   : carry into bit 0
//   sum   : W-bit slice result
//   cout  : carry out of bit W-1
//   cmsb  : carry into bit W-1 (used for signed overflow on the top slice)
//   zero  : sum == 0
module dsp_addsub_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb,
  output logic         zero
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum  = full[W-1:0];
  assign cout = full[W];
  // The sum bit is a ^ b ^ carry_in, so the carry into the MSB falls out by XOR.
  assign cmsb = full[W-1] ^ a[W-1] ^ b[W-1];
  assign zero = ~|full[W-1:0];

endmodule

// File: rtl/dsp_addsub_pipe.sv
// Pipelined WIDTH-bit add/subtract unit, one SLICE_W-bit slice per stage with the
// carry registered between stages. Valid/ready handshake on both sides.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   flush                  : synchronous drop of all in-flight operations
//   in_valid/in_ready      : input handshake
//   in_op                  : OP_ADD (a+b) or OP_SUB (a-b)
//   in_a, in_b, in_tag     : operands and opaque tag
//   out_valid/out_ready    : output handshake
//   out_sum, out_tag       : result and its tag
//   out_carry, out_ovf     : MSB carry-out, signed overflow
//   out_zero, out_neg      : result zero, result sign
module dsp_addsub_pipe
  import dsp_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = MAC16_HALF_W,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int LAST   = NSLICE - 1;

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("dsp_addsub_pipe: WIDTH must be a non-zero multiple of SLICE_W");
  end

  // Stage k registers hold the state after slice k has been added.
  logic             vld_p  [NSLICE];
  logic [WIDTH-1:0] a_p    [NSLICE];
  logic [WIDTH-1:0] b_p    [NSLICE];
  logic [WIDTH-1:0] sum_p  [NSLICE];
  logic             cy_p   [NSLICE];
  logic             ovf_p  [NSLICE];
  logic             zero_p [NSLICE];
  logic [TAG_W-1:0] tag_p  [NSLICE];

  // Inputs seen by each slice adder, and the slice adder outputs.
  logic [WIDTH-1:0]   a_in    [NSLICE];
  logic [WIDTH-1:0]   b_in    [NSLICE];
  logic [WIDTH-1:0]   sum_in  [NSLICE];
  logic               cin     [NSLICE];
  logic               zero_in [NSLICE];
  logic [WIDTH-1:0]   sum_nx  [NSLICE];
  logic [SLICE_W-1:0] s_sum   [NSLICE];
  logic               s_cout  [NSLICE];
  logic               s_cmsb  [NSLICE];
  logic               s_zero  [NSLICE];

  logic             stall;
  logic [WIDTH-1:0] b_eff;

  assign stall    = vld_p[LAST] && !out_ready;
  assign in_ready = !stall;

  // Subtract is a + ~b + 1: b is inverted once at entry and the +1 is slice 0's
  // carry-in, so op itself never needs to travel down the pipe.
  assign b_eff = (in_op == OP_ADD) ? in_b : ~in_b;

  always_comb begin
    a_in[0]    = in_a;
    b_in[0]    = b_eff;
    sum_in[0]  = '0;
    cin[0]     = in_op;
    zero_in[0] = 1'b1;
    for (int k = 1; k < NSLICE; k++) begin
      a_in[k]    = a_p[k-1];
      b_in[k]    = b_p[k-1];
      sum_in[k]  = sum_p[k-1];
      cin[k]     = cy_p[k-1];
      zero_in[k] = zero_p[k-1];
    end
    // Lower result slices ride along unchanged; slice k is filled in here.
    for (int k = 0; k < NSLICE; k++) begin
      sum_nx[k] = sum_in[k];
      sum_nx[k][k*SLICE_W +: SLICE_W] = s_sum[k];
    end
  end

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    dsp_addsub_slice #(
      .W (SLICE_W)
    ) u_slice (
      .a    (a_in[k][k*SLICE_W +: SLICE_W]),
      .b    (b_in[k][k*SLICE_W +: SLICE_W]),
      .cin  (cin[k]),
      .sum  (s_sum[k]),
      .cout (s_cout[k]),
      .cmsb (s_cmsb[k]),
      .zero (s_zero[k])
    );
  end

  // ---- stage registers p0 .. p(NSLICE-1); the whole pipe advances together ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSLICE; k++) begin
        vld_p[k]  <= 1'b0;
        a_p[k]    <= '0;
        b_p[k]    <= '0;
        sum_p[k]  <= '0;
        cy_p[k]   <= 1'b0;
        ovf_p[k]  <= 1'b0;
        zero_p[k] <= 1'b0;
        tag_p[k]  <= '0;
      end
    end else begin
      if (flush) begin
        for (int k = 0; k < NSLICE; k++) vld_p[k] <= 1'b0;
      end else if (!stall) begin
        vld_p[0] <= in_valid;
        for (int k = 1; k < NSLICE; k++) vld_p[k] <= vld_p[k-1];
      end
      if (!stall) begin
        tag_p[0] <= in_tag;
        for (int k = 1; k < NSLICE; k++) tag_p[k] <= tag_p[k-1];
        for (int k = 0; k < NSLICE; k++) begin
          a_p[k]    <= a_in[k];
          b_p[k]    <= b_in[k];
          sum_p[k]  <= sum_nx[k];
          cy_p[k]   <= s_cout[k];
          // Only the top stage's value is meaningful: carry into MSB ^ carry out.
          ovf_p[k]  <= s_cmsb[k] ^ s_cout[k];
          zero_p[k] <= zero_in[k] & s_zero[k];
        end
      end
    end
  end

  assign out_valid = vld_p[LAST];
  assign out_sum   = sum_p[LAST];
  assign out_tag   = tag_p[LAST];
  assign out_carry = cy_p[LAST];
  assign out_ovf   = ovf_p[LAST];
  assign out_zero  = zero_p[LAST];
  assign out_neg   = sum_p[LAST][WIDTH-1];

endmodule

// File: tb/tb_dsp_addsub_pipe.sv
module tb_dsp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_sum;
  logic [3:0]  out_tag;
  logic        out_carry, out_ovf, out_zero, out_neg;

  logic        w_flush, w_in_valid, w_in_ready, w_in_op;
  logic [63:0] w_in_a, w_in_b;
  logic [3:0]  w_in_tag;
  logic        w_out_valid, w_out_ready;
  logic [63:0] w_out_sum;
  logic [3:0]  w_out_tag;
  logic        w_out_carry, w_out_ovf, w_out_zero, w_out_neg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dsp_addsub_pipe #(.WIDTH(32), .SLICE_W(16), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_tag(out_tag), .out_carry(out_carry), .out_ovf(out_ovf),
    .out_zero(out_zero), .out_neg(out_neg)
  );

  dsp_addsub_pipe #(.WIDTH(64), .SLICE_W(16), .TAG_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(w_flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_op(w_in_op),
    .in_a(w_in_a), .in_b(w_in_b), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_sum(w_out_sum),
    .out_tag(w_out_tag), .out_carry(w_out_carry), .out_ovf(w_out_ovf),
    .out_zero(w_out_zero), .out_neg(w_out_neg)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  task automatic chk_res(input string tag, input logic [31:0] sum, input logic [3:0] t,
                         input logic c, input logic o, input logic z, input logic n);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".sum"},   out_sum,   sum);
    chk({tag, ".tag"},   out_tag,   t);
    chk({tag, ".carry"}, out_carry, c);
    chk({tag, ".ovf"},   out_ovf,   o);
    chk({tag, ".zero"},  out_zero,  z);
    chk({tag, ".neg"},   out_neg,   n);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    w_flush = 1'b0; w_in_valid = 1'b0; w_in_op = 1'b0;
    w_in_a = '0; w_in_b = '0; w_in_tag = '0; w_out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.out_sum",   out_sum,   32'h0);
    chk("rst.out_tag",   out_tag,   4'h0);
    chk("rst.flags", {out_carry, out_ovf, out_zero, out_neg}, 4'b0000);
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready", in_ready, 1'b1);
    tick;

    // 1: 0xFFFFFFFF + 1
    drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'h5);
    tick;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("t1.lat1.valid", out_valid, 1'b0);
    tick;
    chk_res("t1", 32'h0000_0000, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0);
    tick;
    chk("t1.drain", out_valid, 1'b0);

    // 2: back-to-back subtracts
    drive(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, 4'hA);
    tick;
    drive(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0001, 4'hB);
    tick;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk_res("t2a", 32'h7FFF_FFFF, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0);
    tick;
    chk_res("t2b", 32'hFFFF_FFFF, 4'hB, 1'b0, 1'b0, 1'b0, 1'b1);
    tick;
    chk("t2.drain", out_valid, 1'b0);

    // 3: four ops, stalled for three cycles after the first result
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 32'd16, 32'd1, 4'd1);
    tick;
    drive(1'b1, 1'b0, 32'd32, 32'd2, 4'd2);
    tick;
    chk("t3.first.tag", out_tag, 4'd1);
    chk("t3.first.valid", out_valid, 1'b1);
    drive(1'b1, 1'b0, 32'd48, 32'd3, 4'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t3.stall.in_ready", in_ready, 1'b0);
      tick;
      chk("t3.stall.valid", out_valid, 1'b1);
      chk("t3.stall.tag", out_tag, 4'd1);
      chk("t3.stall.sum", out_sum, 32'd17);
    end
    out_ready = 1'b1;
    #1;
    chk("t3.release.in_ready", in_ready, 1'b1);
    tick;
    chk("t3.r2.tag", out_tag, 4'd2);
    chk("t3.r2.sum", out_sum, 32'd34);
    drive(1'b1, 1'b0, 32'd64, 32'd4, 4'd4);
    tick;
    chk("t3.r3.tag", out_tag, 4'd3);
    chk("t3.r3.sum", out_sum, 32'd51);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick;
    chk("t3.r4.tag", out_tag, 4'd4);
    chk("t3.r4.sum", out_sum, 32'd68);
    chk("t3.r4.valid", out_valid, 1'b1);
    tick;
    chk("t3.drain", out_valid, 1'b0);

    // 4: 64-bit carry across all four slices
    w_in_valid = 1'b1; w_in_op = 1'b0; w_in_tag = 4'h7;
    w_in_a = 64'h0000_FFFF_FFFF_FFFF; w_in_b = 64'h1;
    tick;
    w_in_valid = 1'b0;
    tick;
    tick;
    chk("t4.lat3.valid", w_out_valid, 1'b0);
    tick;
    chk("t4.valid", w_out_valid, 1'b1);
    chk("t4.sum",   w_out_sum,   64'h0001_0000_0000_0000);
    chk("t4.carry", w_out_carry, 1'b0);
    chk("t4.zero",  w_out_zero,  1'b0);
    chk("t4.tag",   w_out_tag,   4'h7);
    tick;
    chk("t4.drain", w_out_valid, 1'b0);

    // 5: reset mid-flight
    drive(1'b1, 1'b0, 32'h100, 32'h23, 4'd6);
    tick;
    drive(1'b1, 1'b0, 32'h200, 32'h45, 4'd7);
    tick;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("t5.pre.valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5.rst.valid", out_valid, 1'b0);
    chk("t5.rst.sum", out_sum, 32'h0);
    tick;
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t5.none.valid", out_valid, 1'b0);
    end
    drive(1'b1, 1'b0, 32'd10, 32'd20, 4'd8);
    tick;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick;
    chk("t5.after.valid", out_valid, 1'b1);
    chk("t5.after.sum", out_sum, 32'd30);
    chk("t5.after.tag", out_tag, 4'd8);

    // 6: flush with one op in flight and a new one offered
    tick;
    drive(1'b1, 1'b0, 32'd1, 32'd1, 4'd9);
    tick;
    drive(1'b1, 1'b0, 32'd2, 32'd2, 4'd10);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("t6.flush.valid", out_valid, 1'b0);
    tick;
    chk("t6.dropped.valid", out_valid, 1'b0);
    drive(1'b1, 1'b0, 32'd3, 32'd4, 4'd11);
    tick;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("t6.lat1.valid", out_valid, 1'b0);
    tick;
    chk_res("t6", 32'd7, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    chk("t6.drain", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
